// File: rtl/bmp_frame_source.sv
// bmp_frame_source: video timing and test-pattern generator feeding a 24-bpp
// BMP writer. Produces vs/hs/de plus {B,G,R} pixel data for a burst of
// back-to-back frames, and presents constant BMP file/info header fields
// derived from the active resolution.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, frames       burst request (sampled in IDLE only), frame count (0 = ignore)
//   pattern_sel         0 gradient, 1 solid, 2 colour bars, 3 checkerboard
//   solid_rgb           colour for the solid pattern
//   vs_out/hs_out/de_out registered timing outputs, active-high
//   data_out            pixel {B,G,R}, 0 outside the active area
//   busy, burst_done    burst in progress, one-cycle end-of-burst pulse
//   bf*/bi*             BMP header fields, byte 0 = first byte in the file
module bmp_frame_source #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [7:0]      frames,
    input  logic [1:0]      pattern_sel,
    input  logic [23:0]     solid_rgb,
    output logic            vs_out,
    output logic            hs_out,
    output logic            de_out,
    output logic [23:0]     data_out,
    output logic            busy,
    output logic            burst_done,
    output logic [1:0][7:0] bfType,
    output logic [3:0][7:0] bfSize,
    output logic [1:0][7:0] bfResrved1,
    output logic [1:0][7:0] bfResrved2,
    output logic [3:0][7:0] bfOffBits,
    output logic [3:0][7:0] biSize,
    output logic [3:0][7:0] biWidth,
    output logic [3:0][7:0] biHeight,
    output logic [1:0][7:0] biPlanes,
    output logic [1:0][7:0] biBitCount,
    output logic [3:0][7:0] biCompression,
    output logic [3:0][7:0] biSizeImage,
    output logic [3:0][7:0] biXPelsPerMeter,
    output logic [3:0][7:0] biYPelsPerMeter,
    output logic [3:0][7:0] biClrUsed,
    output logic [3:0][7:0] biClrImportant
);

    localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
    // BMP rows are padded to a multiple of four bytes.
    localparam int unsigned STRIDE    = (3 * H_ACTIVE + 3) & ~32'd3;
    localparam int unsigned IMG_SIZE  = STRIDE * V_ACTIVE;
    localparam int unsigned FILE_SIZE = 54 + IMG_SIZE;
    localparam int unsigned BAR_W     = ((H_ACTIVE / 8) == 0) ? 1 : (H_ACTIVE / 8);

    localparam logic [11:0] H_ACT_C  = 12'(H_ACTIVE);
    localparam logic [11:0] H_HS_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_ACT_C  = 12'(V_ACTIVE);
    localparam logic [11:0] V_VS_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] BAR_W_C  = 12'(BAR_W);

    // Header fields: elaboration constants, little-endian byte order.
    assign bfType          = {8'h4D, 8'h42};
    assign bfSize          = FILE_SIZE;
    assign bfResrved1      = 16'd0;
    assign bfResrved2      = 16'd0;
    assign bfOffBits       = 32'd54;
    assign biSize          = 32'd40;
    assign biWidth         = H_ACTIVE;
    assign biHeight        = V_ACTIVE;
    assign biPlanes        = 16'd1;
    assign biBitCount      = 16'd24;
    assign biCompression   = 32'd0;
    assign biSizeImage     = IMG_SIZE;
    assign biXPelsPerMeter = 32'd2835;
    assign biYPelsPerMeter = 32'd2835;
    assign biClrUsed       = 32'd0;
    assign biClrImportant  = 32'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;
    logic [11:0] h_cnt_r;
    logic [11:0] v_cnt_r;
    logic [7:0]  frame_cnt_r;
    logic [7:0]  frames_r;
    logic [1:0]  pat_r;
    logic [23:0] solid_r;

    logic        accept_s;
    logic        h_wrap_s;
    logic        v_wrap_s;
    logic        last_frame_s;
    logic [11:0] bar_q_s;
    logic [2:0]  bar_idx_s;
    logic [23:0] pix_s;
    logic        de_nxt_s;
    logic        hs_nxt_s;
    logic        vs_nxt_s;
    logic [23:0] data_nxt_s;
    logic        busy_nxt_s;
    logic        done_nxt_s;

    assign accept_s     = start && (frames != 8'd0);
    assign h_wrap_s     = (h_cnt_r == H_LAST);
    assign v_wrap_s     = (v_cnt_r == V_LAST);
    assign last_frame_s = ((frame_cnt_r + 8'd1) == frames_r);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) next_state_s = S_RUN;
                else          next_state_s = S_IDLE;
            end
            S_RUN: begin
                if (h_wrap_s && v_wrap_s && last_frame_s) next_state_s = S_DONE;
                else                                      next_state_s = S_RUN;
            end
            S_DONE:  next_state_s = S_IDLE;
            default: next_state_s = S_IDLE;
        endcase
    end

    // Raster counters and burst configuration captured at start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_r     <= 12'd0;
            v_cnt_r     <= 12'd0;
            frame_cnt_r <= 8'd0;
            frames_r    <= 8'd0;
            pat_r       <= 2'd0;
            solid_r     <= 24'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    h_cnt_r     <= 12'd0;
                    v_cnt_r     <= 12'd0;
                    frame_cnt_r <= 8'd0;
                    if (accept_s) begin
                        frames_r <= frames;
                        pat_r    <= pattern_sel;
                        solid_r  <= solid_rgb;
                    end
                end
                S_RUN: begin
                    h_cnt_r <= h_wrap_s ? 12'd0 : (h_cnt_r + 12'd1);
                    if (h_wrap_s) begin
                        v_cnt_r <= v_wrap_s ? 12'd0 : (v_cnt_r + 12'd1);
                        if (v_wrap_s) begin
                            frame_cnt_r <= frame_cnt_r + 8'd1;
                        end
                    end
                end
                default: begin
                    h_cnt_r <= h_cnt_r;
                end
            endcase
        end
    end

    // Pattern colour for the current counter position.
    always_comb begin
        bar_q_s   = h_cnt_r / BAR_W_C;
        bar_idx_s = (bar_q_s > 12'd7) ? 3'd7 : bar_q_s[2:0];
        pix_s     = 24'd0;
        case (pat_r)
            2'd0:    pix_s = {frame_cnt_r, v_cnt_r[7:0], h_cnt_r[7:0]};
            2'd1:    pix_s = solid_r;
            2'd2:    pix_s = {{8{bar_idx_s[0]}}, {8{bar_idx_s[1]}}, {8{bar_idx_s[2]}}};
            2'd3:    pix_s = (h_cnt_r[3] ^ v_cnt_r[3]) ? 24'hFFFFFF : 24'h000000;
            default: pix_s = 24'd0;
        endcase
    end

    // Output decode: next values of every registered output.
    always_comb begin
        de_nxt_s   = 1'b0;
        hs_nxt_s   = 1'b0;
        vs_nxt_s   = 1'b0;
        data_nxt_s = 24'd0;
        if (state_r == S_RUN) begin
            de_nxt_s   = (h_cnt_r < H_ACT_C) && (v_cnt_r < V_ACT_C);
            hs_nxt_s   = (h_cnt_r >= H_HS_BEG) && (h_cnt_r < H_HS_END);
            vs_nxt_s   = (v_cnt_r >= V_VS_BEG) && (v_cnt_r < V_VS_END);
            data_nxt_s = de_nxt_s ? pix_s : 24'd0;
        end else begin
            de_nxt_s   = 1'b0;
        end
        busy_nxt_s = (next_state_s == S_RUN);
        done_nxt_s = (next_state_s == S_DONE);
    end

    // Output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vs_out     <= 1'b0;
            hs_out     <= 1'b0;
            de_out     <= 1'b0;
            data_out   <= 24'd0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            vs_out     <= vs_nxt_s;
            hs_out     <= hs_nxt_s;
            de_out     <= de_nxt_s;
            data_out   <= data_nxt_s;
            busy       <= busy_nxt_s;
            burst_done <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_bmp_frame_source.sv
// Self-checking bench for bmp_frame_source: two instances (a tiny 5x2 raster
// and a 16x12 raster) driven with directed and random bursts, every output
// cycle compared against an arithmetic raster model.
module tb_bmp_frame_source;

    localparam int AH = 5,  AHF = 1, AHS = 1, AHB = 1, AV = 2,  AVF = 1, AVS = 1, AVB = 1;
    localparam int BH = 16, BHF = 2, BHS = 2, BHB = 2, BV = 12, BVF = 1, BVS = 1, BVB = 1;

    logic        clk;
    logic        rst;
    logic        start_a;
    logic        start_b;
    logic [7:0]  frames;
    logic [1:0]  pattern_sel;
    logic [23:0] solid_rgb;

    logic vs_a, hs_a, de_a, busy_a, done_pulse_a;
    logic vs_b, hs_b, de_b, busy_b, done_pulse_b;
    logic [23:0] data_a, data_b;

    logic [1:0][7:0] bf_type_a, bf_res1_a, bf_res2_a, bi_planes_a, bi_bits_a;
    logic [3:0][7:0] bf_size_a, bf_off_a, bi_size_a, bi_width_a, bi_height_a, bi_comp_a;
    logic [3:0][7:0] bi_img_a, bi_xppm_a, bi_yppm_a, bi_clru_a, bi_clri_a;
    logic [1:0][7:0] bf_type_b, bf_res1_b, bf_res2_b, bi_planes_b, bi_bits_b;
    logic [3:0][7:0] bf_size_b, bf_off_b, bi_size_b, bi_width_b, bi_height_b, bi_comp_b;
    logic [3:0][7:0] bi_img_b, bi_xppm_b, bi_yppm_b, bi_clru_b, bi_clri_b;

    int n_checks = 0;
    int n_errors = 0;
    int done_a = 0;
    int done_b = 0;
    int exp_done_a = 0;
    int exp_done_b = 0;

    bmp_frame_source #(.H_ACTIVE(AH), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
                       .V_ACTIVE(AV), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .frames(frames),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .vs_out(vs_a), .hs_out(hs_a), .de_out(de_a), .data_out(data_a),
        .busy(busy_a), .burst_done(done_pulse_a),
        .bfType(bf_type_a), .bfSize(bf_size_a), .bfResrved1(bf_res1_a),
        .bfResrved2(bf_res2_a), .bfOffBits(bf_off_a), .biSize(bi_size_a),
        .biWidth(bi_width_a), .biHeight(bi_height_a), .biPlanes(bi_planes_a),
        .biBitCount(bi_bits_a), .biCompression(bi_comp_a), .biSizeImage(bi_img_a),
        .biXPelsPerMeter(bi_xppm_a), .biYPelsPerMeter(bi_yppm_a),
        .biClrUsed(bi_clru_a), .biClrImportant(bi_clri_a)
    );

    bmp_frame_source #(.H_ACTIVE(BH), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
                       .V_ACTIVE(BV), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .frames(frames),
        .pattern_sel(pattern_sel), .solid_rgb(solid_rgb),
        .vs_out(vs_b), .hs_out(hs_b), .de_out(de_b), .data_out(data_b),
        .busy(busy_b), .burst_done(done_pulse_b),
        .bfType(bf_type_b), .bfSize(bf_size_b), .bfResrved1(bf_res1_b),
        .bfResrved2(bf_res2_b), .bfOffBits(bf_off_b), .biSize(bi_size_b),
        .biWidth(bi_width_b), .biHeight(bi_height_b), .biPlanes(bi_planes_b),
        .biBitCount(bi_bits_b), .biCompression(bi_comp_b), .biSizeImage(bi_img_b),
        .biXPelsPerMeter(bi_xppm_b), .biYPelsPerMeter(bi_yppm_b),
        .biClrUsed(bi_clru_b), .biClrImportant(bi_clri_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count end-of-burst pulses independently of the per-cycle checks.
    always @(posedge clk) begin
        if (done_pulse_a === 1'b1) done_a++;
        if (done_pulse_b === 1'b1) done_b++;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int htot(input bit w);
        return w ? (BH + BHF + BHS + BHB) : (AH + AHF + AHS + AHB);
    endfunction

    function automatic int vtot(input bit w);
        return w ? (BV + BVF + BVS + BVB) : (AV + AVF + AVS + AVB);
    endfunction

    // Reference: {vs,hs,de,data} expected for cycle k of a burst.
    function automatic logic [26:0] exp_out(input bit w, input int k, input int pat,
                                            input logic [23:0] solid);
        int ha, hfp, hsw, va, vfp, vsw, x, y, f, line, bw, idx;
        logic de, hs, vs;
        logic [23:0] d;
        ha  = w ? BH : AH;   hfp = w ? BHF : AHF;  hsw = w ? BHS : AHS;
        va  = w ? BV : AV;   vfp = w ? BVF : AVF;  vsw = w ? BVS : AVS;
        x    = k % htot(w);
        line = k / htot(w);
        y    = line % vtot(w);
        f    = line / vtot(w);
        de = (x < ha) && (y < va);
        hs = (x >= ha + hfp) && (x < ha + hfp + hsw);
        vs = (y >= va + vfp) && (y < va + vfp + vsw);
        d  = 24'd0;
        if (de) begin
            case (pat)
                0: d = {8'(f % 256), 8'(y % 256), 8'(x % 256)};
                1: d = solid;
                2: begin
                    bw  = (ha / 8 < 1) ? 1 : ha / 8;
                    idx = x / bw;
                    if (idx > 7) idx = 7;
                    d = {((idx % 2) == 1) ? 8'hFF : 8'h00,
                         (((idx / 2) % 2) == 1) ? 8'hFF : 8'h00,
                         (((idx / 4) % 2) == 1) ? 8'hFF : 8'h00};
                end
                default: d = (((x / 8) % 2) != ((y / 8) % 2)) ? 24'hFFFFFF : 24'h000000;
            endcase
        end
        return {vs, hs, de, d};
    endfunction

    // Observed {busy, burst_done, vs, hs, de, data} of one instance.
    function automatic logic [28:0] obs_of(input bit w);
        return w ? {busy_b, done_pulse_b, vs_b, hs_b, de_b, data_b}
                 : {busy_a, done_pulse_a, vs_a, hs_a, de_a, data_a};
    endfunction

    task automatic check_hdr(input bit w);
        int ha, va, img;
        ha  = w ? BH : AH;
        va  = w ? BV : AV;
        img = ((3 * ha + 3) / 4) * 4 * va;
        check_eq("bfType",   w ? bf_type_b : bf_type_a, 64'h4D42);
        check_eq("bfType_b0", w ? bf_type_b[0] : bf_type_a[0], 64'h42);
        check_eq("bfSize",   w ? bf_size_b : bf_size_a, 64'(54 + img));
        check_eq("bfRes1",   w ? bf_res1_b : bf_res1_a, 64'd0);
        check_eq("bfRes2",   w ? bf_res2_b : bf_res2_a, 64'd0);
        check_eq("bfOffBits", w ? bf_off_b : bf_off_a, 64'd54);
        check_eq("biSize",   w ? bi_size_b : bi_size_a, 64'd40);
        check_eq("biWidth",  w ? bi_width_b : bi_width_a, 64'(ha));
        check_eq("biHeight", w ? bi_height_b : bi_height_a, 64'(va));
        check_eq("biPlanes", w ? bi_planes_b : bi_planes_a, 64'd1);
        check_eq("biBitCount", w ? bi_bits_b : bi_bits_a, 64'd24);
        check_eq("biCompression", w ? bi_comp_b : bi_comp_a, 64'd0);
        check_eq("biSizeImage", w ? bi_img_b : bi_img_a, 64'(img));
        check_eq("biSizeImage_b0", w ? bi_img_b[0] : bi_img_a[0], 64'(img % 256));
        check_eq("biXPels", w ? bi_xppm_b : bi_xppm_a, 64'd2835);
        check_eq("biYPels", w ? bi_yppm_b : bi_yppm_a, 64'd2835);
        check_eq("biClrUsed", w ? bi_clru_b : bi_clru_a, 64'd0);
        check_eq("biClrImportant", w ? bi_clri_b : bi_clri_a, 64'd0);
    endtask

    // One burst from a negedge; optionally re-pulses start with new inputs mid-burst.
    task automatic run_burst(input bit w, input int nfr, input int pat,
                             input logic [23:0] solid, input bit repulse);
        int total;
        total       = nfr * htot(w) * vtot(w);
        frames      = 8'(nfr);
        pattern_sel = 2'(pat);
        solid_rgb   = solid;
        if (w) start_b = 1'b1; else start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        start_b = 1'b0;
        check_eq("accept", 64'(obs_of(w)), {35'd0, 2'b10, 27'd0});
        for (int k = 0; k < total; k++) begin
            if (repulse && k == 2) begin
                frames      = 8'd9;
                pattern_sel = pattern_sel + 2'd1;
                solid_rgb   = 24'($urandom);
                if (w) start_b = 1'b1; else start_a = 1'b1;
            end
            if (repulse && k == 3) begin
                start_a = 1'b0;
                start_b = 1'b0;
            end
            @(negedge clk);
            check_eq($sformatf("cyc%0d_k%0d", w, k), 64'(obs_of(w)),
                     {35'd0, (k + 1 < total), (k + 1 == total), exp_out(w, k, pat, solid)});
        end
        @(negedge clk);
        check_eq("after_burst", 64'(obs_of(w)), 64'd0);
        if (w) exp_done_b++; else exp_done_a++;
    endtask

    initial begin
        bit found;
        int d0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
        frames = 8'd0; pattern_sel = 2'd0; solid_rgb = 24'd0;
        #1;
        check_hdr(1'b0);
        check_hdr(1'b1);
        #1;
        check_eq("rst_a", 64'(obs_of(1'b0)), 64'd0);
        check_eq("rst_b", 64'(obs_of(1'b1)), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_a", 64'(obs_of(1'b0)), 64'd0);

        // Directed: single gradient frame, then three solid frames back to back.
        run_burst(1'b0, 1, 0, 24'd0, 1'b0);
        run_burst(1'b0, 3, 1, 24'h123456, 1'b0);

        // frames = 0 is ignored.
        frames = 8'd0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("frames0_idle", 64'(obs_of(1'b0)), 64'd0);
        end

        // start re-pulsed with changed inputs while busy has no effect.
        run_burst(1'b0, 2, 0, 24'd0, 1'b1);

        // Asynchronous reset in the middle of an active line.
        d0 = done_a;
        frames = 8'd2; pattern_sel = 2'd0; start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (de_a === 1'b1 && data_a[7:0] == 8'd2) found = 1'b1;
        end
        check_eq("mid_line_seen", 64'(found), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_clear", 64'(obs_of(1'b0)), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_eq("abort_no_done", 64'(done_a), 64'(d0));
        run_burst(1'b0, 1, 3, 24'd0, 1'b0);

        // Wider raster: colour bars and checkerboard.
        run_burst(1'b1, 1, 2, 24'd0, 1'b0);
        run_burst(1'b1, 1, 3, 24'd0, 1'b0);

        // Random bursts on either instance.
        for (int i = 0; i < 6; i++) begin
            bit w;
            w = 1'($urandom_range(0, 1));
            run_burst(w, w ? $urandom_range(1, 2) : $urandom_range(1, 3),
                      $urandom_range(0, 3), 24'($urandom), 1'($urandom_range(0, 1)));
        end

        check_eq("done_cnt_a", 64'(done_a), 64'(exp_done_a));
        check_eq("done_cnt_b", 64'(done_b), 64'(exp_done_b));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
